uart_tx_arbiter: RTL and testbench

- Shares one UART_TX transmitter among NUM_REQ independent requesters using round-robin arbitration.
- Latches the winner's byte and parity configuration, then issues a single-cycle DATA_VALID to the transmitter.
- Tracks the transmitter's Busy through the frame and returns a one-cycle acknowledge to the winner.
- Sits between client logic (register file, FIFOs) and the UART_TX top.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rr_picker.sv | 29 ++
 rtl/uart_tx_arbiter.sv | 150 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side blocks: arbiter state encoding,
// parity-type constants and a grant-index width helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    GAP       = 3'd4
  } arb_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // A single requester still needs a one-bit index.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin search: returns the first asserted request at or after
// ptr, wrapping modulo NUM_REQ. Shared by TX and future RX schedulers.
module uart_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               valid,
  output logic [ID_W-1:0]    winner
);

  function automatic logic [ID_W-1:0] wrap_index(input logic [ID_W-1:0] base, input int off);
    logic [ID_W:0] sum;
    sum = {1'b0, base} + (ID_W+1)'(off);
    if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
    return sum[ID_W-1:0];
  endfunction

  // Scan from the farthest offset down so the request nearest ptr is written last.
  always_comb begin
    valid  = |req;
    winner = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      if (req[wrap_index(ptr, off)]) winner = wrap_index(ptr, off);
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART_TX among NUM_REQ clients: latch, launch, track Busy, ack.
// Define UART_TX_ARB_GAP_EN to insert GAP_CYCLES idle cycles between frames.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int  NUM_REQ      = 4,
  parameter int  DATA_WIDTH   = 8,
  parameter int  BUSY_TIMEOUT = 15,
  parameter int  GAP_CYCLES   = 4,
  localparam int ID_W         = id_width(NUM_REQ)
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            REQ,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
  input  logic [NUM_REQ-1:0]            REQ_PAR_EN,
  input  logic [NUM_REQ-1:0]            REQ_PAR_TYP,
  input  logic                          TX_BUSY,
  output logic                          TX_DATA_VALID,
  output logic [DATA_WIDTH-1:0]         TX_P_DATA,
  output logic                          TX_PAR_EN,
  output logic                          TX_PAR_TYP,
  output logic [NUM_REQ-1:0]            ACK,
  output logic [ID_W-1:0]               GRANT_ID,
  output logic                          ARB_BUSY,
  output logic                          ERR_TIMEOUT
);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("uart_tx_arbiter: NUM_REQ must be 2..8");
  end
  if (BUSY_TIMEOUT < 1 || BUSY_TIMEOUT > 255) begin : g_bad_timeout
    $error("uart_tx_arbiter: BUSY_TIMEOUT must be 1..255");
  end
  if (GAP_CYCLES < 1 || GAP_CYCLES > 255) begin : g_bad_gap
    $error("uart_tx_arbiter: GAP_CYCLES must be 1..255");
  end

  localparam logic [7:0] TIMEOUT_LAST = 8'(BUSY_TIMEOUT - 1);

  arb_state_e            state;
  logic [ID_W-1:0]       ptr;
  logic [7:0]            busy_cnt;
  logic                  pick_valid;
  logic [ID_W-1:0]       pick_id;
  logic [ID_W-1:0]       next_ptr;
  logic [DATA_WIDTH-1:0] slot_data [NUM_REQ];

`ifdef UART_TX_ARB_GAP_EN
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
  logic [7:0] gap_cnt;
`endif

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    assign slot_data[i] = REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
  end

  uart_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req    (REQ),
    .ptr    (ptr),
    .valid  (pick_valid),
    .winner (pick_id)
  );

  assign next_ptr = (int'(GRANT_ID) == NUM_REQ - 1) ? '0 : GRANT_ID + 1'b1;

  // Strobes default low each cycle so VALID, ACK and ERR are single-cycle pulses.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state         <= IDLE;
      ptr           <= '0;
      busy_cnt      <= '0;
`ifdef UART_TX_ARB_GAP_EN
      gap_cnt       <= '0;
`endif
      TX_DATA_VALID <= 1'b0;
      TX_P_DATA     <= '0;
      TX_PAR_EN     <= 1'b0;
      TX_PAR_TYP    <= PAR_EVEN;
      ACK           <= '0;
      GRANT_ID      <= '0;
      ARB_BUSY      <= 1'b0;
      ERR_TIMEOUT   <= 1'b0;
    end else begin
      TX_DATA_VALID <= 1'b0;
      ACK           <= '0;
      ERR_TIMEOUT   <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid && !TX_BUSY) begin
            TX_P_DATA     <= slot_data[pick_id];
            TX_PAR_EN     <= REQ_PAR_EN[pick_id];
            TX_PAR_TYP    <= REQ_PAR_TYP[pick_id];
            GRANT_ID      <= pick_id;
            TX_DATA_VALID <= 1'b1;
            ACK           <= NUM_REQ'(1) << pick_id;
            ARB_BUSY      <= 1'b1;
            state         <= LAUNCH;
          end
        end
        LAUNCH: begin
          ptr      <= next_ptr;
          busy_cnt <= '0;
          state    <= WAIT_BUSY;
        end
        // Busy is checked before the timeout so a coincident rise still completes the frame.
        WAIT_BUSY: begin
          if (TX_BUSY) begin
            state <= WAIT_DONE;
          end else if (busy_cnt == TIMEOUT_LAST) begin
            ERR_TIMEOUT <= 1'b1;
            ARB_BUSY    <= 1'b0;
            state       <= IDLE;
          end else begin
            busy_cnt <= busy_cnt + 8'd1;
          end
        end
        WAIT_DONE: begin
          if (!TX_BUSY) begin
`ifdef UART_TX_ARB_GAP_EN
            gap_cnt <= '0;
            state   <= GAP;
`else
            ARB_BUSY <= 1'b0;
            state    <= IDLE;
`endif
          end
        end
`ifdef UART_TX_ARB_GAP_EN
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            ARB_BUSY <= 1'b0;
            state    <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
`endif
        default: begin
          ARB_BUSY <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed requests push expected launches into a scoreboard
// that a free-running monitor checks; TX Busy is driven by hand per frame.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int NUM_REQ      = 4;
  localparam int DATA_WIDTH   = 8;
  localparam int BUSY_TIMEOUT = 15;
  localparam int GAP_CYCLES   = 4;
`ifdef UART_TX_ARB_GAP_EN
  localparam int   GAP_EXTRA   = GAP_CYCLES;
  localparam logic BUSY_IN_GAP = 1'b1;
`else
  localparam int   GAP_EXTRA   = 0;
  localparam logic BUSY_IN_GAP = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] ack;
    logic [7:0] data;
    logic       parEn;
    logic       parTyp;
    logic [1:0] gid;
  } launch_t;

  logic        clock;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] reqData;
  logic [3:0]  reqParEn;
  logic [3:0]  reqParTyp;
  logic        txBusy;
  logic        txDataValid;
  logic [7:0]  txPData;
  logic        txParEn;
  logic        txParTyp;
  logic [3:0]  ack;
  logic [1:0]  grantId;
  logic        arbBusy;
  logic        errTimeout;

  launch_t expQ[$];
  int testsRun    = 0;
  int testsFailed = 0;
  int errAllowed  = 0;

  uart_tx_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .DATA_WIDTH   (DATA_WIDTH),
    .BUSY_TIMEOUT (BUSY_TIMEOUT),
    .GAP_CYCLES   (GAP_CYCLES)
  ) dut (
    .CLK           (clock),
    .RST           (reset),
    .REQ           (req),
    .REQ_DATA      (reqData),
    .REQ_PAR_EN    (reqParEn),
    .REQ_PAR_TYP   (reqParTyp),
    .TX_BUSY       (txBusy),
    .TX_DATA_VALID (txDataValid),
    .TX_P_DATA     (txPData),
    .TX_PAR_EN     (txParEn),
    .TX_PAR_TYP    (txParTyp),
    .ACK           (ack),
    .GRANT_ID      (grantId),
    .ARB_BUSY      (arbBusy),
    .ERR_TIMEOUT   (errTimeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pushExpect(input int winner);
    launch_t x;
    x.ack    = 4'b0001 << winner;
    x.data   = reqData[winner*DATA_WIDTH +: DATA_WIDTH];
    x.parEn  = reqParEn[winner];
    x.parTyp = reqParTyp[winner];
    x.gid    = 2'(winner);
    expQ.push_back(x);
  endtask

  task automatic applyStimulus(input logic [3:0] mask);
    tick();
    req = mask;
  endtask

  // Counts rising edges until a launch is visible; -1 when the budget runs out.
  task automatic waitLaunch(output int n);
    n = 0;
    while (n < 50) begin
      @(posedge clock);
      n++;
      @(negedge clock);
      if (txDataValid) return;
    end
    testsRun++;
    testsFailed++;
    $display("[TB] FAIL launch_wait: no TX_DATA_VALID within 50 cycles, expected a launch");
    n = -1;
  endtask

  task automatic serveFrame(input int delay, input int len);
    repeat (delay) @(posedge clock);
    #1 txBusy = 1'b1;
    repeat (len) @(posedge clock);
    #1 txBusy = 1'b0;
  endtask

  // Monitor: every launch must match the oldest scoreboard entry; ACK is silent otherwise.
  initial begin
    launch_t e;
    forever begin
      @(negedge clock);
      if (txDataValid) begin
        if (expQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL unexpected_launch: ack=%b grant=%0d, expected no launch", ack, grantId);
        end else begin
          e = expQ.pop_front();
          checkOutput("launch_ack", 32'(ack), 32'(e.ack));
          checkOutput("launch_data", 32'(txPData), 32'(e.data));
          checkOutput("launch_par_en", 32'(txParEn), 32'(e.parEn));
          checkOutput("launch_par_typ", 32'(txParTyp), 32'(e.parTyp));
          checkOutput("launch_grant_id", 32'(grantId), 32'(e.gid));
        end
      end else begin
        checkOutput("ack_idle", 32'(ack), 32'd0);
      end
      if (errTimeout) begin
        testsRun++;
        if (errAllowed > 0) begin
          errAllowed--;
        end else begin
          testsFailed++;
          $display("[TB] FAIL unexpected_err_timeout: got 1, expected 0");
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int launches;
    int delays [5] = '{1, 4, 11, 15, 2};
    int lens   [5] = '{3, 6, 2, 5, 4};

    reset     = 1'b1;
    req       = '0;
    reqData   = '0;
    reqParEn  = '0;
    reqParTyp = '0;
    txBusy    = 1'b0;
    @(negedge clock);
    checkOutput("reset_outputs", 32'({txDataValid, txPData, txParEn, txParTyp, ack, grantId, arbBusy, errTimeout}), 32'd0);
    tick();
    reset = 1'b0;

    // Reset asserted while the transmitter is busy mid-frame.
    reqData = 32'h4433_223C; reqParEn = 4'b0001; reqParTyp = 4'b0000;
    pushExpect(0);
    applyStimulus(4'b0001);
    waitLaunch(n);
    checkOutput("req_to_launch_latency", 32'(n), 32'd1);
    req = 4'b0000;
    serveFrame(1, 0);
    txBusy = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("arb_busy_in_wait_done", 32'(arbBusy), 32'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("reset_mid_frame", 32'({txDataValid, txPData, txParEn, txParTyp, ack, grantId, arbBusy, errTimeout}), 32'd0);
    tick();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("arb_busy_after_reset", 32'(arbBusy), 32'd0);
    tick();
    txBusy = 1'b0;
    repeat (2) tick();

    // All four requesting: pointer restarted at 0 so order is 0,1,2,3,0.
    reqData = 32'h4433_2211; reqParEn = 4'b0101; reqParTyp = 4'b0011;
    pushExpect(0); pushExpect(1); pushExpect(2); pushExpect(3); pushExpect(0);
    applyStimulus(4'b1111);
    for (int k = 0; k < 5; k++) begin
      waitLaunch(n);
      if (k == 4) req = 4'b0000;
      serveFrame(delays[k], lens[k]);
    end
    repeat (GAP_EXTRA + 3) tick();

    // Single request from requester 2; payload must hold after the client changes it.
    reqData = 32'h66A5_4433; reqParEn = 4'b0100; reqParTyp = 4'b0100;
    pushExpect(2);
    applyStimulus(4'b0100);
    waitLaunch(n);
    checkOutput("single_latency", 32'(n), 32'd1);
    req = 4'b0000;
    reqData = 32'h665A_4433;
    reqParTyp = 4'b0000;
    repeat (3) @(posedge clock);
    #1 txBusy = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("data_hold", 32'(txPData), 32'hA5);
    checkOutput("par_en_hold", 32'(txParEn), 32'd1);
    checkOutput("par_typ_hold", 32'(txParTyp), 32'(PAR_ODD));
    checkOutput("grant_id_hold", 32'(grantId), 32'd2);
    checkOutput("arb_busy_frame", 32'(arbBusy), 32'd1);
    tick();
    txBusy = 1'b0;
    @(posedge clock);
    @(negedge clock);
    checkOutput("arb_busy_after_done", 32'(arbBusy), 32'(BUSY_IN_GAP));
    repeat (GAP_EXTRA + 2) tick();

    // External Busy blocks the launch until it falls.
    txBusy = 1'b1;
    reqData = 32'h0000_007E; reqParEn = 4'b0000; reqParTyp = 4'b0000;
    pushExpect(0);
    applyStimulus(4'b0001);
    launches = 0;
    repeat (6) begin
      @(negedge clock);
      if (txDataValid) launches++;
    end
    checkOutput("busy_blocks_launch", 32'(launches), 32'd0);
    tick();
    txBusy = 1'b0;
    waitLaunch(n);
    checkOutput("launch_after_busy_release", 32'(n), 32'd1);
    req = 4'b0000;
    serveFrame(2, 3);
    repeat (GAP_EXTRA + 2) tick();

    // Busy never rises: abort after the timeout, pointer wraps from 3 to 0.
    reqData = 32'hC300_0000; reqParEn = 4'b1000; reqParTyp = {PAR_EVEN, 3'b000};
    pushExpect(3);
    errAllowed = 1;
    applyStimulus(4'b1000);
    waitLaunch(n);
    req = 4'b0000;
    n = 0;
    while (n < 40) begin
      @(posedge clock);
      @(negedge clock);
      n++;
      if (errTimeout) break;
    end
    checkOutput("timeout_latency", 32'(n), 32'(BUSY_TIMEOUT + 1));
    @(negedge clock);
    checkOutput("err_single_pulse", 32'(errTimeout), 32'd0);
    checkOutput("idle_after_timeout", 32'(arbBusy), 32'd0);
    checkOutput("err_seen", 32'(errAllowed), 32'd0);
    reqData = 32'h0000_0019; reqParEn = 4'b0001; reqParTyp = 4'b0001;
    pushExpect(0);
    applyStimulus(4'b0001);
    waitLaunch(n);
    req = 4'b0000;
    serveFrame(3, 2);
    repeat (GAP_EXTRA + 2) tick();

    // Pointer now 1: requesters 0 and 3 pending gives 3 first, then 0.
    reqData = 32'hD200_00E1; reqParEn = 4'b1001; reqParTyp = 4'b1000;
    pushExpect(3); pushExpect(0);
    applyStimulus(4'b1001);
    waitLaunch(n);
    repeat (2) @(posedge clock);
    #1 txBusy = 1'b1;
    repeat (3) @(posedge clock);
    #1 txBusy = 1'b0;
    n = 0;
    while (n < 30) begin
      @(posedge clock);
      n++;
      @(negedge clock);
      if (txDataValid) break;
    end
    checkOutput("busy_fall_to_launch", 32'(n), 32'(2 + GAP_EXTRA));
    req = 4'b0000;
    serveFrame(1, 2);
    repeat (GAP_EXTRA + 4) tick();

    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
    checkOutput("err_budget", 32'(errAllowed), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
